// File: rtl/code_entry_fsm.sv
// code_entry_fsm: keypad code-entry controller for the safe.
//
// Collects a NUM_DIGITS-digit BCD code, one digit per confirm pulse, and
// compares it with the stored code. A match opens the safe. A wrong code
// pulses fail_pulse and uses up one attempt. When the last attempt is used,
// the block enters a timed lockout with the alarm on.
//
// Optional feature (define CODE_PROGRAM_EN): while the safe is unlocked,
// set_code_pulse starts entry of a new code. The new code replaces the
// stored code after its last digit. Without the macro, the stored code is
// the constant DEFAULT_CODE and set_code_pulse is ignored.
//
// Ports:
//   clk                 system clock
//   sys_reset           synchronous active-high reset
//   current_digit       digit offered by the digit selector
//   confirm_pulse       accept current_digit (one-cycle pulse)
//   clear_pulse         discard the partial entry (one-cycle pulse)
//   lock_pulse          relock when unlocked, or abort programming
//   set_code_pulse      start code programming (feature build only)
//   enable_digit_select 1 while digits are accepted (ENTRY / PROGRAM)
//   digit_index         slot that the next digit is written to
//   unlocked            safe open
//   alarm               lockout active
//   fail_pulse          one-cycle pulse on a wrong code
//   attempts_left       remaining attempts before lockout
//   state_dbg           ENTRY=0 CHECK=1 UNLOCKED=2 LOCKOUT=3 PROGRAM=4
module code_entry_fsm #(
    parameter int unsigned                 NUM_DIGITS     = 4,
    parameter logic [4*NUM_DIGITS-1:0]     DEFAULT_CODE   = 16'h1234,
    parameter int unsigned                 MAX_ATTEMPTS   = 3,
    parameter int unsigned                 LOCKOUT_CYCLES = 50000000
) (
    input  logic                          clk,
    input  logic                          sys_reset,
    input  logic [3:0]                    current_digit,
    input  logic                          confirm_pulse,
    input  logic                          clear_pulse,
    input  logic                          lock_pulse,
    input  logic                          set_code_pulse,
    output logic                          enable_digit_select,
    output logic [$clog2(NUM_DIGITS)-1:0] digit_index,
    output logic                          unlocked,
    output logic                          alarm,
    output logic                          fail_pulse,
    output logic [3:0]                    attempts_left,
    output logic [2:0]                    state_dbg
);

    localparam int unsigned CW  = 4 * NUM_DIGITS;
    localparam int unsigned IW  = $clog2(NUM_DIGITS);
    localparam int unsigned LCW = $clog2(LOCKOUT_CYCLES + 1);

    localparam logic [IW-1:0]  LAST_IDX  = IW'(NUM_DIGITS - 1);
    localparam logic [3:0]     ATT_MAX   = 4'(MAX_ATTEMPTS);
    localparam logic [LCW-1:0] LOCK_LOAD = LCW'(LOCKOUT_CYCLES);
    localparam logic [LCW-1:0] LOCK_LAST = LCW'(1);

    typedef enum logic [2:0] {
        ST_ENTRY    = 3'd0,
        ST_CHECK    = 3'd1,
        ST_UNLOCKED = 3'd2,
        ST_LOCKOUT  = 3'd3,
        ST_PROGRAM  = 3'd4
    } state_t;

    state_t         state;
    logic [CW-1:0]  entry_buf;
    logic [LCW-1:0] lock_cnt;
    logic [CW-1:0]  active_code;

    // Digit slot 0 occupies the MSB nibble, so the slot shift is 4*digit_index.
    logic            digit_valid;
    logic [IW+1:0]   slot_shift;
    logic [CW-1:0]   slot_mask;
    logic [CW-1:0]   slot_digit;
    logic [CW-1:0]   buf_written;
    logic            code_match;

    assign digit_valid = (current_digit <= 4'd9);
    assign slot_shift  = {digit_index, 2'b00};
    assign slot_mask   = {4'hF, {(CW-4){1'b0}}} >> slot_shift;
    assign slot_digit  = {current_digit, {(CW-4){1'b0}}} >> slot_shift;
    assign buf_written = (entry_buf & ~slot_mask) | slot_digit;
    assign code_match  = (entry_buf == active_code);

    assign state_dbg = 3'(state);

`ifdef CODE_PROGRAM_EN
    logic [CW-1:0] stored_code;
    assign active_code = stored_code;
`else
    logic unused_set_code;
    assign active_code     = DEFAULT_CODE;
    assign unused_set_code = set_code_pulse;
`endif

    // Controller state, entry buffer, lockout timer and all registered outputs.
    always_ff @(posedge clk) begin
        if (sys_reset) begin
            state               <= ST_ENTRY;
            entry_buf           <= '0;
            digit_index         <= '0;
            attempts_left       <= ATT_MAX;
            unlocked            <= 1'b0;
            alarm               <= 1'b0;
            fail_pulse          <= 1'b0;
            lock_cnt            <= '0;
            enable_digit_select <= 1'b1;
`ifdef CODE_PROGRAM_EN
            stored_code         <= DEFAULT_CODE;
`endif
        end else begin
            fail_pulse <= 1'b0;

            case (state)
                ST_ENTRY: begin
                    if (clear_pulse) begin
                        entry_buf   <= '0;
                        digit_index <= '0;
                    end else if (confirm_pulse && digit_valid) begin
                        entry_buf <= buf_written;
                        if (digit_index == LAST_IDX) begin
                            state               <= ST_CHECK;
                            enable_digit_select <= 1'b0;
                        end else begin
                            digit_index <= digit_index + IW'(1);
                        end
                    end
                end

                // Single-cycle compare; the entry is always wiped on the way out.
                ST_CHECK: begin
                    entry_buf   <= '0;
                    digit_index <= '0;
                    if (code_match) begin
                        state               <= ST_UNLOCKED;
                        unlocked            <= 1'b1;
                        attempts_left       <= ATT_MAX;
                        enable_digit_select <= 1'b0;
                    end else if (attempts_left > 4'd1) begin
                        state               <= ST_ENTRY;
                        attempts_left       <= attempts_left - 4'd1;
                        fail_pulse          <= 1'b1;
                        enable_digit_select <= 1'b1;
                    end else begin
                        state               <= ST_LOCKOUT;
                        attempts_left       <= 4'd0;
                        fail_pulse          <= 1'b1;
                        alarm               <= 1'b1;
                        lock_cnt            <= LOCK_LOAD;
                        enable_digit_select <= 1'b0;
                    end
                end

                ST_UNLOCKED: begin
                    if (lock_pulse) begin
                        state               <= ST_ENTRY;
                        unlocked            <= 1'b0;
                        enable_digit_select <= 1'b1;
                    end
`ifdef CODE_PROGRAM_EN
                    else if (set_code_pulse) begin
                        state               <= ST_PROGRAM;
                        entry_buf           <= '0;
                        digit_index         <= '0;
                        enable_digit_select <= 1'b1;
                    end
`endif
                end

                // Counter holds the remaining alarm cycles; leaving on 1 gives
                // exactly LOCKOUT_CYCLES cycles of alarm.
                ST_LOCKOUT: begin
                    lock_cnt <= lock_cnt - LCW'(1);
                    if (lock_cnt == LOCK_LAST) begin
                        state               <= ST_ENTRY;
                        alarm               <= 1'b0;
                        attempts_left       <= ATT_MAX;
                        enable_digit_select <= 1'b1;
                    end
                end

`ifdef CODE_PROGRAM_EN
                ST_PROGRAM: begin
                    if (lock_pulse) begin
                        state               <= ST_ENTRY;
                        unlocked            <= 1'b0;
                        entry_buf           <= '0;
                        digit_index         <= '0;
                        enable_digit_select <= 1'b1;
                    end else if (clear_pulse) begin
                        entry_buf   <= '0;
                        digit_index <= '0;
                    end else if (confirm_pulse && digit_valid) begin
                        if (digit_index == LAST_IDX) begin
                            stored_code         <= buf_written;
                            entry_buf           <= '0;
                            digit_index         <= '0;
                            state               <= ST_UNLOCKED;
                            enable_digit_select <= 1'b0;
                        end else begin
                            entry_buf   <= buf_written;
                            digit_index <= digit_index + IW'(1);
                        end
                    end
                end
`endif

                // Illegal encoding: return to reset values but keep the stored code.
                default: begin
                    state               <= ST_ENTRY;
                    entry_buf           <= '0;
                    digit_index         <= '0;
                    attempts_left       <= ATT_MAX;
                    unlocked            <= 1'b0;
                    alarm               <= 1'b0;
                    fail_pulse          <= 1'b0;
                    lock_cnt            <= '0;
                    enable_digit_select <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: doc/code_entry_fsm.md
Name: code_entry_fsm

Overview:
Consumes current_digit from digit_selector and gates it through enable_digit_select. Accumulates a NUM_DIGITS-digit code one digit per confirm pulse and compares it with the stored code. Drives the safe's unlocked and alarm outputs, with an attempt limit and a timed lockout. Button pulses arrive already conditioned as one-cycle pulses from the upstream pulse stage.

Parameters:
NUM_DIGITS, 4, code length in digits (2..8); code width CW = 4*NUM_DIGITS.
DEFAULT_CODE, 16'h1234, stored code after reset (BCD, first-entered digit in MSBs); width CW.
MAX_ATTEMPTS, 3, consecutive wrong codes allowed before lockout (1..15).
LOCKOUT_CYCLES, 50000000, lockout duration in clk cycles (>=1).

Ports:
clk  in  1  system clock
sys_reset  in  1  synchronous active-high reset
current_digit  in  4  digit from digit_selector
confirm_pulse  in  1  one-cycle pulse: accept current_digit
clear_pulse  in  1  one-cycle pulse: discard partial entry
lock_pulse  in  1  one-cycle pulse: relock when unlocked
set_code_pulse  in  1  one-cycle pulse: start code programming (feature only)
enable_digit_select  out  1  to digit_selector; 1 only while digits are accepted
digit_index  out  $clog2(NUM_DIGITS)  position of next digit to enter
unlocked  out  1  safe open
alarm  out  1  lockout active
fail_pulse  out  1  one-cycle pulse on wrong code
attempts_left  out  4  remaining attempts
state_dbg  out  3  encoded state: ENTRY=0 CHECK=1 UNLOCKED=2 LOCKOUT=3 PROGRAM=4

Behaviour:
- One clock; sys_reset synchronous, active-high, overrides everything in the same edge, including mid-entry, mid-lockout and mid-programming.
- Reset values: state ENTRY, entry buffer 0, digit_index 0, attempts_left MAX_ATTEMPTS, unlocked 0, alarm 0, fail_pulse 0, lockout counter 0, stored code DEFAULT_CODE, enable_digit_select 1.
- enable_digit_select is 1 in ENTRY and PROGRAM, 0 otherwise. It is a registered output tracking the next state.
- ENTRY:
  - confirm_pulse with current_digit <= 9: write the digit into buffer slot digit_index, slot 0 = bits [CW-1:CW-4].
  - If digit_index == NUM_DIGITS-1, go to CHECK; otherwise increment digit_index.
  - current_digit > 9: pulse ignored, no index change.
  - clear_pulse: buffer 0, digit_index 0. clear_pulse wins over a simultaneous confirm_pulse.
  - lock_pulse and set_code_pulse are ignored.
- CHECK: lasts exactly one cycle and ignores all pulses. On exit, buffer and digit_index are cleared.
  - Buffer == stored code: go to UNLOCKED, attempts_left = MAX_ATTEMPTS.
  - Mismatch with attempts_left > 1: decrement attempts_left, fail_pulse = 1 for one cycle, go to ENTRY.
  - Mismatch with attempts_left == 1: attempts_left = 0, fail_pulse = 1, lockout counter = LOCKOUT_CYCLES, go to LOCKOUT.
- Latency: last confirm sampled at edge N; state is CHECK after edge N; unlocked, fail_pulse or alarm asserts after edge N+1.
- UNLOCKED: unlocked = 1.
  - lock_pulse: go to ENTRY with unlocked = 0 after the same edge.
  - confirm_pulse and clear_pulse are ignored.
  - lock_pulse wins over a simultaneous set_code_pulse.
- LOCKOUT: alarm = 1; counter decrements every cycle and all pulses are ignored. When the counter reaches 1, the next edge goes to ENTRY with alarm 0 and attempts_left MAX_ATTEMPTS. Alarm lasts exactly LOCKOUT_CYCLES cycles.
- attempts_left is held wide enough for MAX_ATTEMPTS <= 15 and never underflows.
- An unused state encoding recovers to ENTRY using reset values, except that the stored code is retained.

Optional Feature:
Macro CODE_PROGRAM_EN.
- Defined:
  - set_code_pulse in UNLOCKED enters PROGRAM with buffer 0 and digit_index 0; unlocked stays 1.
  - PROGRAM uses the same digit/confirm/clear rules as ENTRY.
  - After the last digit, the buffer is copied to the stored code and the next state is UNLOCKED.
  - lock_pulse in PROGRAM aborts: stored code unchanged, go to ENTRY, unlocked 0.
- Undefined: set_code_pulse is ignored, PROGRAM is unreachable, stored code is the constant DEFAULT_CODE, and state_dbg never reads 4.

Test Plan:
Use NUM_DIGITS=4, DEFAULT_CODE=16'h1234, MAX_ATTEMPTS=3, LOCKOUT_CYCLES=8.
1. Reset, then confirm 1,2,3,4 -> digit_index steps 0..3 then back to 0; unlocked=1 two edges after the 4th confirm; enable_digit_select=0; attempts_left=3.
2. Enter 1,2,3,5 -> one-cycle fail_pulse, attempts_left=2, state ENTRY, unlocked=0. Then enter 1,2,3,4 -> unlocked=1 and attempts_left=3.
3. Three wrong codes -> alarm=1 for exactly 8 cycles; confirms during lockout ignored; then ENTRY with attempts_left=3.
4. Confirm 1,2; assert clear_pulse and confirm_pulse in the same cycle -> digit_index=0. Confirm with current_digit=4'hC -> no index change.
5. Unlocked, then lock_pulse -> unlocked=0 next edge. sys_reset asserted during lockout and mid-entry -> all outputs return to reset values on the following edge.
6. With CODE_PROGRAM_EN: unlock, set_code_pulse, enter 9,8,7,6, lock_pulse -> code 1234 fails and 9876 unlocks. After sys_reset, 1234 unlocks again.
